// File: rtl/ys_poly_small_seq_pkg.sv
// Shared types and helpers for the ys_poly_small read/write sequencer.
package ys_poly_small_seq_pkg;

  localparam int unsigned N_COEF_DEF        = 677;
  localparam int unsigned COEF_PER_WORD_DEF = 4;
  localparam int unsigned ADDR_W_DEF        = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } seq_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ys_poly_small_seq_wrpipe.sv
// One-stage delay aligning ram2 write address/enables and f_ctr with the ram1 read latency.
module ys_poly_small_seq_wrpipe #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addra_i,
  input  logic [ADDR_W-1:0] addrb_i,
  input  logic              valid_i,
  input  logic              b_ok_i,
  input  logic              first_i,
  output logic [ADDR_W-1:0] addra_o,
  output logic [ADDR_W-1:0] addrb_o,
  output logic              wea_o,
  output logic              web_o,
  output logic              f_ctr_o
);

  logic [ADDR_W-1:0] addra_d, addra_q;
  logic [ADDR_W-1:0] addrb_d, addrb_q;
  logic              wea_d, wea_q;
  logic              web_d, web_q;
  logic              first_d, first_q;

  always_comb begin
    addra_d = addra_i;
    addrb_d = addrb_i;
    wea_d   = valid_i;
    web_d   = valid_i & b_ok_i;
    first_d = valid_i & first_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addra_q <= '0;
      addrb_q <= '0;
      wea_q   <= 1'b0;
      web_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      addra_q <= addra_d;
      addrb_q <= addrb_d;
      wea_q   <= wea_d;
      web_q   <= web_d;
      first_q <= first_d;
    end
  end

  assign addra_o = addra_q;
  assign addrb_o = addrb_q;
  assign wea_o   = wea_q;
  assign web_o   = web_q;
  // exe3 negates-and-triples g[0] only when f_ctr is low on the first write beat.
  assign f_ctr_o = ~first_q;

endmodule

// File: rtl/ys_poly_small_seq.sv
// Address/control sequencer streaming a polynomial from ram1 through an execute unit into ram2.
module ys_poly_small_seq
  import ys_poly_small_seq_pkg::*;
#(
  parameter int unsigned N_COEF        = N_COEF_DEF,
  parameter int unsigned COEF_PER_WORD = COEF_PER_WORD_DEF,
  parameter int unsigned ADDR_W        = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic [1:0]        mode_q,
  output logic [ADDR_W-1:0] ram1_addra,
  output logic [ADDR_W-1:0] ram1_addrb,
  output logic              ram1_en,
  output logic              f_ctr,
  output logic [ADDR_W-1:0] ram2_addra,
  output logic [ADDR_W-1:0] ram2_addrb,
  output logic              ram2_wea,
  output logic              ram2_web
);

  localparam int unsigned NUM_WORDS = ceil_div(N_COEF, COEF_PER_WORD);
  localparam int unsigned NUM_BEATS = ceil_div(NUM_WORDS, 2);
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(NUM_BEATS - 1);

  if (2 * NUM_BEATS > (1 << ADDR_W)) begin : g_addr_range_check
    $error("ys_poly_small_seq: 2*NUM_BEATS exceeds the ADDR_W address space");
  end
  if (NUM_BEATS == 0) begin : g_nonempty_check
    $error("ys_poly_small_seq: N_COEF must be non-zero");
  end

  seq_state_e        state_d, state_q;
  logic [ADDR_W-1:0] k_d, k_q;
  logic [1:0]        mode_d, mode_lat_q;

  logic              rd_valid;
  logic              rd_first;
  logic              rd_b_ok;
  logic [ADDR_W:0]   odd_word;
  logic [ADDR_W-1:0] rd_addra;
  logic [ADDR_W-1:0] rd_addrb;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    mode_d   = mode_lat_q;
    rd_valid = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          k_d     = '0;
          state_d = StRead;
        end
      end
      StRead: begin
        // Back-to-back beats: the exe3 carry register assumes no bubbles.
        rd_valid = 1'b1;
        k_d      = k_q + 1'b1;
        if (k_q == LAST_BEAT) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    odd_word = {k_q, 1'b1};
    rd_first = (k_q == '0);
    // Odd word past the end of the polynomial is never written.
    rd_b_ok  = (32'(odd_word) < NUM_WORDS);
    rd_addra = rd_valid ? {k_q[ADDR_W-2:0], 1'b0} : '0;
    rd_addrb = rd_valid ? odd_word[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      mode_lat_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      mode_lat_q <= mode_d;
    end
  end

  ys_poly_small_seq_wrpipe #(
    .ADDR_W (ADDR_W)
  ) u_wrpipe (
    .clk     (clk),
    .rst     (rst),
    .addra_i (rd_addra),
    .addrb_i (rd_addrb),
    .valid_i (rd_valid),
    .b_ok_i  (rd_b_ok),
    .first_i (rd_first),
    .addra_o (ram2_addra),
    .addrb_o (ram2_addrb),
    .wea_o   (ram2_wea),
    .web_o   (ram2_web),
    .f_ctr_o (f_ctr)
  );

  assign busy       = (state_q != StIdle);
  assign mode_q     = mode_lat_q;
  assign ram1_addra = rd_addra;
  assign ram1_addrb = rd_addrb;
  assign ram1_en    = rd_valid;

endmodule

// File: tb/tb_ys_poly_small_seq.sv
// Self-checking bench: cycle-exact event model of reads, writes, f_ctr, busy and done.
module tb_ys_poly_small_seq;

  localparam int BIG = 1 << 30;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       sel;
  logic       start_a;
  logic       start_b;

  logic       a_busy, a_done, a_en, a_f_ctr, a_wea, a_web;
  logic [1:0] a_mode_q;
  logic [7:0] a_r1a, a_r1b, a_r2a, a_r2b;
  logic       b_busy, b_done, b_en, b_f_ctr, b_wea, b_web;
  logic [1:0] b_mode_q;
  logic [7:0] b_r1a, b_r1b, b_r2a, b_r2b;

  int total;
  int bad;

  assign start_a = sel ? 1'b0 : start;
  assign start_b = sel ? start : 1'b0;

  ys_poly_small_seq u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start_a),
    .mode       (mode),
    .busy       (a_busy),
    .done       (a_done),
    .mode_q     (a_mode_q),
    .ram1_addra (a_r1a),
    .ram1_addrb (a_r1b),
    .ram1_en    (a_en),
    .f_ctr      (a_f_ctr),
    .ram2_addra (a_r2a),
    .ram2_addrb (a_r2b),
    .ram2_wea   (a_wea),
    .ram2_web   (a_web)
  );

  ys_poly_small_seq #(
    .N_COEF (9)
  ) u_dut9 (
    .clk        (clk),
    .rst        (rst),
    .start      (start_b),
    .mode       (mode),
    .busy       (b_busy),
    .done       (b_done),
    .mode_q     (b_mode_q),
    .ram1_addra (b_r1a),
    .ram1_addrb (b_r1b),
    .ram1_en    (b_en),
    .f_ctr      (b_f_ctr),
    .ram2_addra (b_r2a),
    .ram2_addrb (b_r2b),
    .ram2_wea   (b_wea),
    .ram2_web   (b_web)
  );

  wire       o_busy  = sel ? b_busy  : a_busy;
  wire       o_done  = sel ? b_done  : a_done;
  wire       o_en    = sel ? b_en    : a_en;
  wire       o_f_ctr = sel ? b_f_ctr : a_f_ctr;
  wire       o_wea   = sel ? b_wea   : a_wea;
  wire       o_web   = sel ? b_web   : a_web;
  wire [1:0] o_mode  = sel ? b_mode_q : a_mode_q;
  wire [7:0] o_r1a   = sel ? b_r1a   : a_r1a;
  wire [7:0] o_r1b   = sel ? b_r1b   : a_r1b;
  wire [7:0] o_r2a   = sel ? b_r2a   : a_r2a;
  wire [7:0] o_r2b   = sel ? b_r2b   : a_r2b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Called at a negedge with the selected DUT idle; issues start there (cycle 0).
  // Beat j is read in cycle j+1 and written in cycle j+2; done lands in cycle nb+2.
  task automatic run_op(input int nb, input int nw, input logic [1:0] m,
                        input int sp1, input int sp2, input int rst_at);
    bit ab;
    bit rd;
    bit wr;
    int jr;
    int jw;
    chk("idle_busy", 0, 32'(o_busy), 32'(0));
    start = 1'b1;
    mode  = m;
    for (int c = 1; c <= nb + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      ab = (c > rst_at);
      jr = c - 1;
      jw = c - 2;
      rd = !ab && (jr < nb);
      wr = !ab && (jw >= 0) && (jw < nb);
      chk("ram1_en", c, 32'(o_en), 32'(rd));
      if (rd) begin
        chk("ram1_addra", c, 32'(o_r1a), 32'(2 * jr));
        chk("ram1_addrb", c, 32'(o_r1b), 32'(2 * jr + 1));
      end
      chk("ram2_wea", c, 32'(o_wea), 32'(wr));
      chk("ram2_web", c, 32'(o_web), 32'(wr && (2 * jw + 1 < nw)));
      if (wr) begin
        chk("ram2_addra", c, 32'(o_r2a), 32'(2 * jw));
        chk("ram2_addrb", c, 32'(o_r2b), 32'(2 * jw + 1));
      end
      chk("f_ctr", c, 32'(o_f_ctr), 32'(!(wr && jw == 0)));
      chk("busy", c, 32'(o_busy), 32'(!ab && c <= nb + 2));
      chk("done", c, 32'(o_done), 32'(!ab && c == nb + 2));
      chk("mode_q", c, 32'(o_mode), ab ? 32'(0) : 32'(m));
      if (!ab && c < rst_at && (c == sp1 || c == sp2)) begin
        start = 1'b1;
        mode  = 2'($urandom);
      end
      if (c == rst_at) begin
        rst   = 1'b1;
        start = 1'($urandom_range(0, 1));
        mode  = 2'($urandom);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    sel   = 1'b0;
    rst   = 1'b1;
    start = 1'b1;
    mode  = 2'd3;
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, 32'(a_busy), 32'(0));
    chk("rst_done", 0, 32'(a_done), 32'(0));
    chk("rst_en", 0, 32'(a_en), 32'(0));
    chk("rst_wea", 0, 32'(a_wea), 32'(0));
    chk("rst_web", 0, 32'(a_web), 32'(0));
    chk("rst_f_ctr", 0, 32'(a_f_ctr), 32'(1));
    chk("rst_mode_q", 0, 32'(a_mode_q), 32'(0));
    chk("rst_r1a", 0, 32'(a_r1a), 32'(0));
    chk("rst_r2a", 0, 32'(a_r2a), 32'(0));
    chk("rst_r2b", 0, 32'(a_r2b), 32'(0));
    chk("rst9_f_ctr", 0, 32'(b_f_ctr), 32'(1));
    chk("rst9_busy", 0, 32'(b_busy), 32'(0));
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);

    // Nominal mode 3 with stray starts at beats 10 and 50.
    run_op(85, 170, 2'd3, 11, 51, BIG);
    // Reset at beat 40 aborts; a fresh start then runs to completion.
    run_op(85, 170, 2'd3, 5, -1, 41);
    run_op(85, 170, 2'd2, -1, -1, BIG);
    // Back-to-back: start in the cycle right after done.
    run_op(85, 170, 2'd1, 87, -1, BIG);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk("gap_busy", 0, 32'(a_busy), 32'(0));
      end
      run_op(85, 170, 2'($urandom), $urandom_range(1, 87), $urandom_range(1, 87), BIG);
    end

    // N_COEF=9: three words, odd port masked on the last beat.
    sel = 1'b1;
    @(negedge clk);
    run_op(2, 3, 2'd3, 2, 4, BIG);
    run_op(2, 3, 2'd0, -1, -1, BIG);
    run_op(2, 3, 2'd3, 1, -1, 2);
    for (int i = 0; i < 4; i++) begin
      run_op(2, 3, 2'($urandom), $urandom_range(1, 4), $urandom_range(1, 4), BIG);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
